key_sched_ctrl: RTL and testbench

//  Sequencer for the AES-128 round-key datapath (one KeyExpand instance + one 128b key register).

---
 rtl/key_sched_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl
// Sequencer for the AES-128 round-key datapath: one key-expansion stage plus one
// 128-bit key register. It serves round keys RK0..RK10 (encrypt) or RK10..RK0
// (decrypt) over a valid/ready handshake. Decrypt first walks the schedule
// forward to RK10 (PRE), then steps back with the inverse expansion.
// Optional feature macro: KEY_CACHE_EN. When defined, the last decrypt start key
// and its RK10 are remembered so a repeated decrypt start can skip PRE.
module key_sched_ctrl #(
  parameter int NRND  = 10,
  parameter int RND_W = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic              i_fDec,
  input  logic [127:0]      i_Key,
  input  logic              i_KeyRdy,
  output logic              o_KeyVld,
  output logic [127:0]      o_RndKey,
  output logic [RND_W-1:0]  o_Rnd,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam logic [RND_W-1:0] LP_LAST    = RND_W'(NRND);
  localparam logic [RND_W-1:0] LP_PRE_END = RND_W'(NRND - 1);
  localparam logic [RND_W-1:0] LP_ONE     = RND_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_ISSUE} state_t;

  state_t             r_State;
  state_t             w_NextState;
  logic [127:0]       r_KeyReg;
  logic [RND_W-1:0]   r_Cnt;
  logic [RND_W-1:0]   r_Rnd;
  logic               r_Dec;
  logic               r_Done;

  logic               w_Xfer;
  logic               w_Last;
  logic               w_Step;
  logic               w_Finish;
  logic               w_PreDone;
  logic               w_Hit;
  logic [127:0]       w_StartKey;
  logic [RND_W-1:0]   w_ExpRnd;
  logic               w_ExpDec;
  logic [127:0]       w_ExpKey;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] sBox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for step index 0..9; anything else maps to zero
  function automatic logic [7:0] rCon(input logic [RND_W-1:0] r);
    case (r)
      RND_W'(0): return 8'h01;
      RND_W'(1): return 8'h02;
      RND_W'(2): return 8'h04;
      RND_W'(3): return 8'h08;
      RND_W'(4): return 8'h10;
      RND_W'(5): return 8'h20;
      RND_W'(6): return 8'h40;
      RND_W'(7): return 8'h80;
      RND_W'(8): return 8'h1b;
      RND_W'(9): return 8'h36;
      default:   return 8'h00;
    endcase
  endfunction

  assign w_Xfer    = (r_State == ST_ISSUE) && i_KeyRdy;
  assign w_Last    = r_Dec ? (r_Rnd == '0) : (r_Rnd == LP_LAST);
  assign w_Step    = w_Xfer && !w_Last;
  assign w_Finish  = w_Xfer && w_Last;
  assign w_PreDone = (r_State == ST_PRE) && (r_Cnt == LP_PRE_END);

`ifdef KEY_CACHE_EN
  logic [127:0] r_CacheKey;
  logic [127:0] r_CacheLast;
  logic         r_CacheVld;

  assign w_Hit      = r_CacheVld && (i_Key == r_CacheKey);
  assign w_StartKey = (i_fDec && w_Hit) ? r_CacheLast : i_Key;

  // Cache bookkeeping: invalidate on a decrypt miss, fill when its pre-pass reaches RK10
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_CacheKey  <= '0;
      r_CacheLast <= '0;
      r_CacheVld  <= 1'b0;
    end else begin
      if ((r_State == ST_IDLE) && i_Start && i_fDec && !w_Hit) begin
        r_CacheVld <= 1'b0;
        r_CacheKey <= i_Key;
      end else if (w_PreDone) begin
        r_CacheLast <= w_ExpKey;
        r_CacheVld  <= 1'b1;
      end
    end
  end
`else
  assign w_Hit      = 1'b0;
  assign w_StartKey = i_Key;
`endif

  // Operand select for the shared expansion stage; the index stays at zero whenever no step is taken
  always_comb begin
    w_ExpRnd = '0;
    w_ExpDec = 1'b0;
    if (r_State == ST_PRE) begin
      w_ExpRnd = r_Cnt;
    end else if ((r_State == ST_ISSUE) && !w_Last) begin
      if (r_Dec) begin
        w_ExpRnd = r_Rnd - LP_ONE;
        w_ExpDec = 1'b1;
      end else begin
        w_ExpRnd = r_Rnd;
      end
    end
  end

  // Single expansion stage, forward or inverse; both directions share one SubWord of the word that becomes w3
  always_comb begin
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] sw, t;
    logic [31:0] n0, n1, n2, n3;
    k0 = r_KeyReg[127:96];
    k1 = r_KeyReg[95:64];
    k2 = r_KeyReg[63:32];
    k3 = r_KeyReg[31:0];
    sw = w_ExpDec ? (k3 ^ k2) : k3;
    t  = {sBox(sw[23:16]), sBox(sw[15:8]), sBox(sw[7:0]), sBox(sw[31:24])} ^
         {rCon(w_ExpRnd), 24'h000000};
    if (w_ExpDec) begin
      n3 = k3 ^ k2;
      n2 = k2 ^ k1;
      n1 = k1 ^ k0;
      n0 = k0 ^ t;
    end else begin
      n0 = k0 ^ t;
      n1 = k1 ^ n0;
      n2 = k2 ^ n1;
      n3 = k3 ^ n2;
    end
    w_ExpKey = {n0, n1, n2, n3};
  end

  // State register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_State <= ST_IDLE;
    else       r_State <= w_NextState;
  end

  // Next-state logic
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      ST_IDLE:  if (i_Start) w_NextState = (i_fDec && !w_Hit) ? ST_PRE : ST_ISSUE;
      ST_PRE:   if (w_PreDone) w_NextState = ST_ISSUE;
      ST_ISSUE: if (w_Finish) w_NextState = ST_IDLE;
      default:  w_NextState = ST_IDLE;
    endcase
  end

  // Datapath: key register, pre-pass counter, round index and done pulse
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_KeyReg <= '0;
      r_Cnt    <= '0;
      r_Rnd    <= '0;
      r_Dec    <= 1'b0;
      r_Done   <= 1'b0;
    end else begin
      r_Done <= w_Finish;
      case (r_State)
        ST_IDLE: begin
          if (i_Start) begin
            r_KeyReg <= w_StartKey;
            r_Cnt    <= '0;
            r_Dec    <= i_fDec;
            r_Rnd    <= i_fDec ? LP_LAST : '0;
          end
        end
        ST_PRE: begin
          r_KeyReg <= w_ExpKey;
          r_Cnt    <= r_Cnt + LP_ONE;
        end
        ST_ISSUE: begin
          if (w_Step) begin
            r_KeyReg <= w_ExpKey;
            r_Rnd    <= r_Dec ? (r_Rnd - LP_ONE) : (r_Rnd + LP_ONE);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come from registered state only, so valid never follows ready combinationally
  always_comb begin
    o_KeyVld = (r_State == ST_ISSUE);
    o_Busy   = (r_State != ST_IDLE);
    o_RndKey = (r_State == ST_ISSUE) ? r_KeyReg : '0;
    o_Rnd    = (r_State == ST_ISSUE) ? r_Rnd : '0;
    o_Done   = r_Done;
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl
// Self-checking bench for key_sched_ctrl. Known AES-128 schedules for two keys
// are held as constants; each run pushes its expected (index, key) sequence to a
// queue and pops one entry per handshake transfer. Build with KEY_CACHE_EN
// defined to expect the shortened repeat-decrypt latency.
module tb_key_sched_ctrl;

  logic         i_Clk;
  logic         i_Rst;
  logic         i_Start;
  logic         i_fDec;
  logic [127:0] i_Key;
  logic         i_KeyRdy;
  logic         o_KeyVld;
  logic [127:0] o_RndKey;
  logic [3:0]   o_Rnd;
  logic         o_Busy;
  logic         o_Done;

  key_sched_ctrl #(.NRND(10), .RND_W(4)) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Start  (i_Start),
    .i_fDec   (i_fDec),
    .i_Key    (i_Key),
    .i_KeyRdy (i_KeyRdy),
    .o_KeyVld (o_KeyVld),
    .o_RndKey (o_RndKey),
    .o_Rnd    (o_Rnd),
    .o_Busy   (o_Busy),
    .o_Done   (o_Done)
  );

`ifdef KEY_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 11;
`endif

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  typedef struct {
    logic dec;
    int   keyIdx;
    logic rndRdy;
    logic disturb;
    logic chain;
    int   expLat;
  } vec_t;

  exp_t         expQ[$];
  logic [127:0] rk[2][11];
  vec_t         vecs[8];
  int           checks;
  int           fails;

  // Free-running clock
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // One comparison: count it, report on mismatch
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All outputs at their reset values
  task automatic checkReset(input string tag);
    checkOutput({tag, "_vld"},  128'(o_KeyVld), 128'd0);
    checkOutput({tag, "_key"},  o_RndKey,       128'd0);
    checkOutput({tag, "_rnd"},  128'(o_Rnd),    128'd0);
    checkOutput({tag, "_busy"}, 128'(o_Busy),   128'd0);
    checkOutput({tag, "_done"}, 128'(o_Done),   128'd0);
  endtask

  // One full schedule run; called at a falling edge, returns at a falling edge
  task automatic applyStimulus(input logic dec, input int keyIdx, input logic rndRdy,
                               input int expLat, input logic disturb, input logic preStarted,
                               input logic chain, input logic chainDec, input int chainKeyIdx);
    int   cyc;
    int   rr;
    logic gotFirst;
    logic rdy;
    if (!preStarted) begin
      i_Start = 1'b1;
      i_fDec  = dec;
      i_Key   = rk[keyIdx][0];
    end
    for (int r = 0; r <= 10; r++) begin
      rr = dec ? (10 - r) : r;
      expQ.push_back('{rnd: 4'(rr), key: rk[keyIdx][rr]});
    end
    cyc      = 0;
    gotFirst = 1'b0;
    while (expQ.size() > 0 && cyc < 300) begin
      @(negedge i_Clk);
      cyc++;
      i_Start = disturb && (cyc % 3 == 0);
      if (disturb) begin
        i_Key  = ~rk[keyIdx][0];
        i_fDec = ~dec;
      end
      rdy = rndRdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gotFirst) checkOutput("vld_held", 128'(o_KeyVld), 128'd1);
      if (o_KeyVld) begin
        if (!gotFirst) begin
          gotFirst = 1'b1;
          checkOutput("first_latency", 128'(cyc), 128'(expLat));
          checkOutput("busy_in_run", 128'(o_Busy), 128'd1);
        end
        checkOutput("rnd_idx", 128'(o_Rnd), 128'(expQ[0].rnd));
        checkOutput("rnd_key", o_RndKey, expQ[0].key);
        if (rdy) void'(expQ.pop_front());
      end
      i_KeyRdy = rdy;
    end
    checkOutput("run_timeout", 128'(expQ.size()), 128'd0);
    expQ.delete();
    @(negedge i_Clk);
    i_KeyRdy = 1'b0;
    i_Start  = 1'b0;
    checkOutput("done_pulse", 128'(o_Done), 128'd1);
    checkOutput("vld_after_last", 128'(o_KeyVld), 128'd0);
    checkOutput("busy_after_last", 128'(o_Busy), 128'd0);
    if (chain) begin
      i_Start = 1'b1;
      i_fDec  = chainDec;
      i_Key   = rk[chainKeyIdx][0];
    end else begin
      @(negedge i_Clk);
      checkOutput("done_one_cycle", 128'(o_Done), 128'd0);
    end
  endtask

  // Main sequence: table rows, then the reset corner cases
  initial begin
    int   cyc;
    logic pre;
    int   nxt;
    checks = 0;
    fails  = 0;

    rk[0][0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    rk[0][1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    rk[0][2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    rk[0][3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    rk[0][4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    rk[0][5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    rk[0][6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    rk[0][7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    rk[0][8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    rk[0][9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    rk[0][10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    rk[1][0]  = 128'h00000000_00000000_00000000_00000000;
    rk[1][1]  = 128'h62636363_62636363_62636363_62636363;
    rk[1][2]  = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
    rk[1][3]  = 128'h90973450_696ccffa_f2f45733_0b0fac99;
    rk[1][4]  = 128'hee06da7b_876a1581_759e42b2_7e91ee2b;
    rk[1][5]  = 128'h7f2e2b88_f8443e09_8dda7cbb_f34b9290;
    rk[1][6]  = 128'hec614b85_1425758c_99ff0937_6ab49ba7;
    rk[1][7]  = 128'h21751787_3550620b_acaf6b3c_c61bf09b;
    rk[1][8]  = 128'h0ef90333_3ba96138_97060a04_511dfa9f;
    rk[1][9]  = 128'hb1d4d8e2_8a7db9da_1d7bb3de_4c664941;
    rk[1][10] = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    //          dec   key rndRdy disturb chain expLat
    vecs[0] = '{1'b0, 0,  1'b0,  1'b0,   1'b0, 1};
    vecs[1] = '{1'b1, 0,  1'b0,  1'b0,   1'b0, 11};
    vecs[2] = '{1'b0, 0,  1'b1,  1'b1,   1'b0, 1};
    vecs[3] = '{1'b1, 0,  1'b0,  1'b0,   1'b1, HIT_LAT};
    vecs[4] = '{1'b0, 1,  1'b0,  1'b0,   1'b0, 1};
    vecs[5] = '{1'b1, 1,  1'b1,  1'b0,   1'b0, 11};
    vecs[6] = '{1'b1, 1,  1'b0,  1'b0,   1'b0, HIT_LAT};
    vecs[7] = '{1'b1, 0,  1'b1,  1'b0,   1'b0, 11};

    i_Rst    = 1'b1;
    i_Start  = 1'b0;
    i_fDec   = 1'b0;
    i_Key    = '0;
    i_KeyRdy = 1'b0;
    repeat (2) @(negedge i_Clk);
    checkReset("reset");
    i_Rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pre = (i > 0) && vecs[i-1].chain;
      nxt = (i < 7) ? i + 1 : i;
      applyStimulus(vecs[i].dec, vecs[i].keyIdx, vecs[i].rndRdy, vecs[i].expLat,
                    vecs[i].disturb, pre, vecs[i].chain, vecs[nxt].dec, vecs[nxt].keyIdx);
    end

    // Reset while issuing round 4 of an encrypt run
    i_Start  = 1'b1;
    i_fDec   = 1'b0;
    i_Key    = rk[0][0];
    i_KeyRdy = 1'b1;
    cyc = 0;
    do begin
      @(negedge i_Clk);
      i_Start = 1'b0;
      cyc++;
    end while (!(o_KeyVld && o_Rnd == 4'd4) && cyc < 50);
    checkOutput("reach_rnd4", 128'(o_Rnd), 128'd4);
    checkOutput("rnd4_key", o_RndKey, rk[0][4]);
    i_Rst = 1'b1;
    #1;
    checkReset("rst_issue");
    @(negedge i_Clk);
    i_Rst    = 1'b0;
    i_KeyRdy = 1'b0;
    applyStimulus(1'b1, 0, 1'b0, 11, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of the decrypt pre-pass
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst   = 1'b0;
    i_Start = 1'b1;
    i_fDec  = 1'b1;
    i_Key   = rk[0][0];
    repeat (5) begin
      @(negedge i_Clk);
      i_Start = 1'b0;
    end
    checkOutput("pre_vld_low", 128'(o_KeyVld), 128'd0);
    checkOutput("pre_busy", 128'(o_Busy), 128'd1);
    i_Rst = 1'b1;
    #1;
    checkReset("rst_pre");
    @(negedge i_Clk);
    i_Rst = 1'b0;
    applyStimulus(1'b1, 0, 1'b0, 11, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
